// File: rtl/cfi_backend_shadow_stack_pkg.sv
// Shared types for the CFI shadow-stack backend: core-level exception and
// address widths (riscv) plus the CFI log entry, fault cause and FSM states.

package riscv;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 39;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;
endpackage

package cfi_pkg;
    localparam int unsigned VLEN = riscv::VLEN;
    localparam int unsigned XLEN = riscv::XLEN;

    typedef enum logic [1:0] {
        CFI_BRANCH = 2'd0,
        CFI_JUMP   = 2'd1,
        CFI_CALL   = 2'd2,
        CFI_RETURN = 2'd3
    } cfi_kind_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        cfi_kind_t       kind;
        logic            rvc;
    } cfi_log_t;

    // Software-check exception code used for backward-edge violations
    localparam logic [XLEN-1:0] CFI_SS_FAULT_CAUSE = XLEN'(18);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } cfi_ss_state_e;

    // Build a fault report for a return whose target failed the check
    function automatic riscv::exception_t cfi_ss_fault(input logic [VLEN-1:0] target);
        riscv::exception_t e;
        e.cause = CFI_SS_FAULT_CAUSE;
        e.tval  = XLEN'(target);
        e.valid = 1'b1;
        return e;
    endfunction
endpackage

// File: rtl/cfi_backend_shadow_stack_if.sv
// Pop-side bundle between the CFI log FIFO and the shadow-stack backend.

interface cfi_backend_shadow_stack_if;
    import cfi_pkg::*;

    cfi_log_t          log_i;
    logic              queue_empty_i;
    logic              queue_pop_o;
    riscv::exception_t cfi_fault_o;

    modport master (
        output log_i,
        output queue_empty_i,
        input  queue_pop_o,
        input  cfi_fault_o
    );

    modport slave (
        input  log_i,
        input  queue_empty_i,
        output queue_pop_o,
        output cfi_fault_o
    );
endinterface

// File: rtl/cfi_backend_shadow_stack_ss_lifo.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest
// entry and the count saturates at SS_DEPTH.

module cfi_ss_lifo
    import cfi_pkg::*;
#(
    parameter int unsigned SS_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push,
    input  logic                        pop,
    input  logic [VLEN-1:0]             data,
    output logic [VLEN-1:0]             top,
    output logic                        empty,
    output logic [$clog2(SS_DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(SS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [VLEN-1:0]  mem [SS_DEPTH];
    logic [PTR_W-1:0] wp;

    // wp is the next free slot; power-of-two depth makes the wrap implicit
    assign top   = mem[wp - PTR_W'(1)];
    assign empty = (count == '0);

    // Storage write, no reset needed since count guards every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wp] <= data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            wp <= wp + PTR_W'(1);
            if (count != CNT_W'(SS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wp    <= wp - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/cfi_backend_shadow_stack.sv
// Shadow-stack CFI backend: drains the CFI log FIFO, pushes return addresses
// on calls and checks returns against the top of stack.
// Build option: CFI_SS_UNDERFLOW_FAULT_EN makes a return on an empty stack fault;
// without it such returns are ignored.

module cfi_backend_shadow_stack
    import cfi_pkg::*;
#(
    parameter int unsigned SS_DEPTH       = 16,
    parameter int unsigned NR_STALL_CHECK = 0
) (
    input logic                         clk_i,
    input logic                         rst_i,
    cfi_backend_shadow_stack_if.slave   bus
);
    localparam int unsigned CNT_W    = $clog2(SS_DEPTH) + 1;
    localparam int unsigned STALL_W  = (NR_STALL_CHECK > 1) ? $clog2(NR_STALL_CHECK + 1) : 1;
    localparam bit          STALL_EN = (NR_STALL_CHECK > 0);
    localparam bit          STALL_FSM_EN = (NR_STALL_CHECK > 1);

    cfi_log_t           s1;
    logic               s1_valid;
    cfi_ss_state_e      state_q, state_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               pop_c;
    logic               ret_exec;
    logic               ss_push, ss_pop, ss_empty;
    logic [VLEN-1:0]    ss_top, ss_push_data;
    logic [CNT_W-1:0]   ss_count;
    logic               unused_ss_count;
    riscv::exception_t  fault_d, fault_q;

    // Occupancy is kept for debug observation only
    assign unused_ss_count = ^ss_count;

    assign bus.queue_pop_o = pop_c;
    assign bus.cfi_fault_o = fault_q;

    cfi_ss_lifo #(
        .SS_DEPTH (SS_DEPTH)
    ) u_lifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (ss_push),
        .pop   (ss_pop),
        .data  (ss_push_data),
        .top   (ss_top),
        .empty (ss_empty),
        .count (ss_count)
    );

    // Capture stage: latch the popped head entry into S1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= pop_c;
            if (pop_c) begin
                s1 <= bus.log_i;
            end
        end
    end

    // Execute stage: stack update and return check on S1
    always_comb begin
        ss_push      = 1'b0;
        ss_pop       = 1'b0;
        ret_exec     = 1'b0;
        fault_d      = '0;
        ss_push_data = s1.pc + (s1.rvc ? VLEN'(2) : VLEN'(4));
        if (s1_valid) begin
            case (s1.kind)
                CFI_CALL: begin
                    ss_push = 1'b1;
                end
                CFI_RETURN: begin
                    ret_exec = 1'b1;
                    if (!ss_empty) begin
                        ss_pop = 1'b1;
                        if (s1.target != ss_top) begin
                            fault_d = cfi_ss_fault(s1.target);
                        end
                    end
`ifdef CFI_SS_UNDERFLOW_FAULT_EN
                    else begin
                        fault_d = cfi_ss_fault(s1.target);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Fault report register: one-cycle pulse per failed check
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= '0;
        end else begin
            fault_q <= fault_d;
        end
    end

    // Stall FSM state and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stall FSM next state and pop strobe; the return's own execute cycle is
    // the first idle cycle, so STALL only covers the remaining NR_STALL_CHECK-1
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        pop_c       = 1'b0;
        case (state_q)
            RUN: begin
                pop_c = !bus.queue_empty_i && !(STALL_EN && ret_exec);
                if (STALL_FSM_EN && ret_exec) begin
                    state_d     = STALL;
                    stall_cnt_d = STALL_W'(NR_STALL_CHECK);
                end
            end
            STALL: begin
                stall_cnt_d = stall_cnt_q - STALL_W'(1);
                if (stall_cnt_q <= STALL_W'(2)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (rst_i) begin
            pop_c = 1'b0;
        end
    end
endmodule
